// File: rtl/wb_regfile_scoreboard_if.sv
// Bus bundle between the WB/ID stages and the register file with scoreboard.
// The master side drives the write, read and mark requests. The slave side returns read data and busy flags.
interface wb_regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  WB_regwrite_i;
    logic [ADDR_WIDTH-1:0] WB_rd_add_i;
    logic [DATA_WIDTH-1:0] WB_data_write_reg_i;
    logic [ADDR_WIDTH-1:0] ID_rs1_add_i;
    logic [ADDR_WIDTH-1:0] ID_rs2_add_i;
    logic [DATA_WIDTH-1:0] ID_rs1_data_o;
    logic [DATA_WIDTH-1:0] ID_rs2_data_o;
    logic                  ID_mark_valid_i;
    logic [ADDR_WIDTH-1:0] ID_mark_add_i;
    logic                  flush_i;
    logic                  ID_rs1_busy_o;
    logic                  ID_rs2_busy_o;
    logic [ADDR_WIDTH:0]   pending_cnt_o;

    modport master (
        output WB_regwrite_i, WB_rd_add_i, WB_data_write_reg_i,
        output ID_rs1_add_i, ID_rs2_add_i, ID_mark_valid_i, ID_mark_add_i, flush_i,
        input  ID_rs1_data_o, ID_rs2_data_o, ID_rs1_busy_o, ID_rs2_busy_o, pending_cnt_o
    );

    modport slave (
        input  WB_regwrite_i, WB_rd_add_i, WB_data_write_reg_i,
        input  ID_rs1_add_i, ID_rs2_add_i, ID_mark_valid_i, ID_mark_add_i, flush_i,
        output ID_rs1_data_o, ID_rs2_data_o, ID_rs1_busy_o, ID_rs2_busy_o, pending_cnt_o
    );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with write-to-read bypass and a per-register pending-write scoreboard.
// Register x0 is hard-wired to zero. Its scoreboard bit is always clear.
module wb_regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_regfile_scoreboard_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   sb;
    logic [NUM_REGS-1:0]   sb_next;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_next;

    logic wr_en;
    logic mark_en;
    logic cnt_inc;
    logic cnt_dec;
    logic rs1_hit;
    logic rs2_hit;

    assign wr_en   = bus.WB_regwrite_i && (bus.WB_rd_add_i != '0);
    assign mark_en = bus.ID_mark_valid_i && (bus.ID_mark_add_i != '0);
    assign rs1_hit = bus.WB_regwrite_i && (bus.WB_rd_add_i == bus.ID_rs1_add_i);
    assign rs2_hit = bus.WB_regwrite_i && (bus.WB_rd_add_i == bus.ID_rs2_add_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.WB_rd_add_i] <= bus.WB_data_write_reg_i;
        end
    end

    // The mark is applied after the clear, so a same-address mark from a younger instruction wins.
    always_comb begin
        sb_next = sb;
        if (bus.flush_i) begin
            sb_next = '0;
        end else begin
            if (wr_en) begin
                sb_next[bus.WB_rd_add_i] = 1'b0;
            end
            if (mark_en) begin
                sb_next[bus.ID_mark_add_i] = 1'b1;
            end
        end
        sb_next[0] = 1'b0;
    end

    // The count tracks the popcount incrementally; inc and dec only fire on real bit transitions.
    always_comb begin
        cnt_inc  = mark_en && !sb[bus.ID_mark_add_i];
        cnt_dec  = wr_en && sb[bus.WB_rd_add_i]
                   && !(mark_en && (bus.ID_mark_add_i == bus.WB_rd_add_i));
        cnt_next = cnt;
        if (bus.flush_i) begin
            cnt_next = '0;
        end else if (cnt_inc && !cnt_dec) begin
            cnt_next = cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb  <= '0;
            cnt <= '0;
        end else begin
            sb  <= sb_next;
            cnt <= cnt_next;
        end
    end

    // Reads are gated by reset so a bypassed write cannot leak through while reset is held.
    always_comb begin
        bus.ID_rs1_data_o = '0;
        if (rst_n && (bus.ID_rs1_add_i != '0)) begin
            bus.ID_rs1_data_o = rs1_hit ? bus.WB_data_write_reg_i : regs[bus.ID_rs1_add_i];
        end
    end

    always_comb begin
        bus.ID_rs2_data_o = '0;
        if (rst_n && (bus.ID_rs2_add_i != '0)) begin
            bus.ID_rs2_data_o = rs2_hit ? bus.WB_data_write_reg_i : regs[bus.ID_rs2_add_i];
        end
    end

    assign bus.ID_rs1_busy_o = sb[bus.ID_rs1_add_i] && !rs1_hit;
    assign bus.ID_rs2_busy_o = sb[bus.ID_rs2_add_i] && !rs2_hit;
    assign bus.pending_cnt_o = cnt;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Randomized and directed bench for wb_regfile_scoreboard.
// The bench checks against an array-based reference model of the register file and scoreboard.
module tb_wb_regfile_scoreboard;
    logic clk;
    logic rst_n;

    wb_regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    wb_regfile_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] modelRegs [32];
    bit          modelSb   [32];

    logic [31:0] lastRs1Data;
    logic [31:0] lastRs2Data;
    logic        lastRs1Busy;
    logic        lastRs2Busy;
    logic [5:0]  lastCnt;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(modelSb[i]);
        return n;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 32; i++) begin
            modelRegs[i] = '0;
            modelSb[i]   = 1'b0;
        end
    endtask

    function automatic logic [31:0] expectData(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return modelRegs[a];
    endfunction

    function automatic logic expectBusy(input logic [4:0] a, input logic we, input logic [4:0] wa);
        if (a == 0) return 1'b0;
        if (we && wa == a) return 1'b0;
        return modelSb[a];
    endfunction

    // One full cycle: drive, check combinational outputs, clock, update model, check the count.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic mv, input logic [4:0] ma, input logic fl);
        bus.WB_regwrite_i       = we;
        bus.WB_rd_add_i         = wa;
        bus.WB_data_write_reg_i = wd;
        bus.ID_rs1_add_i        = r1;
        bus.ID_rs2_add_i        = r2;
        bus.ID_mark_valid_i     = mv;
        bus.ID_mark_add_i       = ma;
        bus.flush_i             = fl;
        #2;
        lastRs1Data = bus.ID_rs1_data_o;
        lastRs2Data = bus.ID_rs2_data_o;
        lastRs1Busy = bus.ID_rs1_busy_o;
        lastRs2Busy = bus.ID_rs2_busy_o;
        checkOutput("rs1_data", lastRs1Data, expectData(r1, we, wa, wd));
        checkOutput("rs2_data", lastRs2Data, expectData(r2, we, wa, wd));
        checkOutput("rs1_busy", lastRs1Busy, expectBusy(r1, we, wa));
        checkOutput("rs2_busy", lastRs2Busy, expectBusy(r2, we, wa));
        @(posedge clk);
        if (we && wa != 0) modelRegs[wa] = wd;
        if (fl) begin
            for (int i = 0; i < 32; i++) modelSb[i] = 1'b0;
        end else begin
            if (we && wa != 0) modelSb[wa] = 1'b0;
            if (mv && ma != 0) modelSb[ma] = 1'b1;
        end
        #1;
        lastCnt = bus.pending_cnt_o;
        checkOutput("pending_cnt", lastCnt, modelCount());
    endtask

    task automatic idleRead(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b0, 5'd0, 32'd0, r1, r2, 1'b0, 5'd0, 1'b0);
    endtask

    function automatic logic [4:0] randAddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic randomCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom(),
                          randAddr(), randAddr(),
                          1'($urandom_range(0, 2) != 0), randAddr(),
                          1'($urandom_range(0, 29) == 0));
        end
    endtask

    initial begin
        rst_n                   = 1'b0;
        bus.WB_regwrite_i       = 1'b0;
        bus.WB_rd_add_i         = '0;
        bus.WB_data_write_reg_i = '0;
        bus.ID_rs1_add_i        = 5'd5;
        bus.ID_rs2_add_i        = 5'd0;
        bus.ID_mark_valid_i     = 1'b0;
        bus.ID_mark_add_i       = '0;
        bus.flush_i             = 1'b0;
        resetModel();

        #12;
        checkOutput("reset_rs1_data", bus.ID_rs1_data_o, 32'd0);
        checkOutput("reset_rs2_data", bus.ID_rs2_data_o, 32'd0);
        checkOutput("reset_rs1_busy", bus.ID_rs1_busy_o, 1'b0);
        checkOutput("reset_rs2_busy", bus.ID_rs2_busy_o, 1'b0);
        checkOutput("reset_cnt", bus.pending_cnt_o, 6'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idleRead(5'd5, 5'd0);

        // Bypass and x0 handling.
        applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("bypass_x7", lastRs1Data, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'h1234, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("stored_x7", lastRs1Data, 32'hDEADBEEF);
        checkOutput("x0_write_ignored", lastRs2Data, 32'd0);

        // Mark, observe busy, retire with bypass.
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        idleRead(5'd9, 5'd0);
        checkOutput("x9_busy", lastRs1Busy, 1'b1);
        checkOutput("x9_cnt", lastCnt, 6'd1);
        applyStimulus(1'b1, 5'd9, 32'h55, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
        checkOutput("x9_busy_bypassed", lastRs1Busy, 1'b0);
        checkOutput("x9_data_bypassed", lastRs1Data, 32'h55);
        checkOutput("x9_cnt_cleared", lastCnt, 6'd0);

        // Same-cycle set and clear.
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        applyStimulus(1'b1, 5'd9, 32'h66, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
        idleRead(5'd9, 5'd0);
        checkOutput("set_wins_busy", lastRs1Busy, 1'b1);
        checkOutput("set_wins_cnt", lastCnt, 6'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
        applyStimulus(1'b1, 5'd3, 32'h77, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        idleRead(5'd3, 5'd4);
        checkOutput("x3_cleared", lastRs1Busy, 1'b0);
        checkOutput("x4_set", lastRs2Busy, 1'b1);
        checkOutput("split_cnt", lastCnt, 6'd2);

        // Fill the scoreboard, then flush with a competing mark.
        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 5'(a), 5'd0, 1'b1, 5'(a), 1'b0);
        end
        checkOutput("full_cnt", lastCnt, 6'd31);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b1, 5'd5, 1'b1);
        checkOutput("flush_cnt", lastCnt, 6'd0);
        idleRead(5'd5, 5'd31);
        checkOutput("flush_busy5", lastRs1Busy, 1'b0);

        randomCycles(400);

        // Asynchronous reset mid-cycle with an in-flight write and mark.
        applyStimulus(1'b1, 5'd12, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0);
        bus.WB_regwrite_i       = 1'b1;
        bus.WB_rd_add_i         = 5'd12;
        bus.WB_data_write_reg_i = 32'h11111111;
        bus.ID_mark_valid_i     = 1'b1;
        bus.ID_mark_add_i       = 5'd12;
        bus.ID_rs1_add_i        = 5'd12;
        bus.ID_rs2_add_i        = 5'd12;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rs1_data", bus.ID_rs1_data_o, 32'd0);
        checkOutput("async_rs1_busy", bus.ID_rs1_busy_o, 1'b0);
        checkOutput("async_cnt", bus.pending_cnt_o, 6'd0);
        resetModel();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        idleRead(5'd12, 5'd12);
        checkOutput("post_reset_x12", lastRs1Data, 32'd0);

        randomCycles(100);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
